reg_ring_initiator: RTL and testbench

Master end of the UDP register ring. Accepts one register read or write at a time from a local command port and injects it at the head of the ring as a single-cycle request tagged with this block's source ID. It then watches the ring tail for that request to return, and hands back the read data plus ack/error status. It is the initiator counterpart of the `generic_regs` responders (the processor control/status registers among them) that sit on the ring.

---
 rtl/reg_ring_initiator_pkg.sv | 27 ++
 rtl/reg_ring_initiator_if.sv | 25 ++
 rtl/reg_ring_initiator.sv | 158 +++++++++++++++
 tb/tb_reg_ring_initiator.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_ring_initiator_pkg.sv
// Shared widths, FSM encoding and response codes for the UDP register ring initiator.
package reg_ring_initiator_pkg;

  localparam int UDP_REG_ADDR_WIDTH  = 23;
  localparam int CPCI_NF2_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } ring_state_e;

  typedef logic [1:0] rsp_err_t;

  localparam rsp_err_t ERR_OK      = 2'b00;
  localparam rsp_err_t ERR_NOACK   = 2'b01;
  localparam rsp_err_t ERR_TIMEOUT = 2'b10;

  localparam logic [CPCI_NF2_DATA_WIDTH-1:0] TIMEOUT_FILL = 32'hDEAD_BEEF;

  // Status code for a claimed return: ack means some responder owned the address.
  function automatic rsp_err_t claim_status(input logic ack);
    return ack ? ERR_OK : ERR_NOACK;
  endfunction

endpackage

// File: rtl/reg_ring_initiator_if.sv
// Local command/response port of the ring initiator; master = host side, slave = initiator.
interface reg_ring_initiator_if;
  import reg_ring_initiator_pkg::*;

  logic                           cmd_valid;
  logic                           cmd_ready;
  logic                           cmd_rd_wr_L;
  logic [UDP_REG_ADDR_WIDTH-1:0]  cmd_addr;
  logic [CPCI_NF2_DATA_WIDTH-1:0] cmd_wdata;
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [CPCI_NF2_DATA_WIDTH-1:0] rsp_rdata;
  rsp_err_t                       rsp_err;

  modport master (
    output cmd_valid, cmd_rd_wr_L, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_rd_wr_L, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/reg_ring_initiator.sv
// UDP register ring master: injects one tagged request, claims its return, reports status.
// Optional return watchdog is built only when REG_RING_TIMEOUT_EN is defined.
module reg_ring_initiator
  import reg_ring_initiator_pkg::*;
#(
  parameter int                           UDP_REG_SRC_WIDTH = 2,
  parameter logic [UDP_REG_SRC_WIDTH-1:0] SRC_ID            = UDP_REG_SRC_WIDTH'(1),
  parameter int                           TIMEOUT_CYCLES    = 1024
) (
  input  logic                           clk,
  input  logic                           reset_n,
  reg_ring_initiator_if.slave            cmd_if,

  output logic                           reg_req_out,
  output logic                           reg_ack_out,
  output logic                           reg_rd_wr_L_out,
  output logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out,
  output logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_out,

  input  logic                           reg_req_in,
  input  logic                           reg_ack_in,
  input  logic                           reg_rd_wr_L_in,
  input  logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in,
  input  logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_in
);

  ring_state_e                    r_state;
  logic                           r_cmd_ready;
  logic                           r_rsp_valid;
  logic [CPCI_NF2_DATA_WIDTH-1:0] r_rsp_rdata;
  rsp_err_t                       r_rsp_err;
  logic [UDP_REG_ADDR_WIDTH-1:0]  r_addr;

  logic                           r_req_out;
  logic                           r_rd_wr_L_out;
  logic [UDP_REG_ADDR_WIDTH-1:0]  r_addr_out;
  logic [CPCI_NF2_DATA_WIDTH-1:0] r_data_out;
  logic [UDP_REG_SRC_WIDTH-1:0]   r_src_out;

  logic                           w_claim;
  logic                           w_unused_ok;

`ifdef REG_RING_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             w_tmo_hit;

  assign w_tmo_hit   = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign w_unused_ok = reg_rd_wr_L_in;
`else
  assign w_unused_ok = reg_rd_wr_L_in ^ 1'(TIMEOUT_CYCLES % 2);
`endif

  // Only our own tagged return for the outstanding address is claimed.
  assign w_claim = (r_state == ST_WAIT) && reg_req_in &&
                   (reg_src_in == SRC_ID) && (reg_addr_in == r_addr);

  // Transaction FSM; every output is a register written here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_cmd_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= ERR_OK;
      r_addr        <= '0;
      r_req_out     <= 1'b0;
      r_rd_wr_L_out <= 1'b0;
      r_addr_out    <= '0;
      r_data_out    <= '0;
      r_src_out     <= '0;
`ifdef REG_RING_TIMEOUT_EN
      r_tmo_cnt     <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_if.cmd_valid && r_cmd_ready) begin
            r_cmd_ready   <= 1'b0;
            r_addr        <= cmd_if.cmd_addr;
            r_req_out     <= 1'b1;
            r_rd_wr_L_out <= cmd_if.cmd_rd_wr_L;
            r_addr_out    <= cmd_if.cmd_addr;
            r_data_out    <= cmd_if.cmd_wdata;
            r_src_out     <= SRC_ID;
            r_state       <= ST_ISSUE;
          end else begin
            r_cmd_ready   <= 1'b1;
          end
        end
        ST_ISSUE: begin
          // Request lives on the ring head for this single cycle only.
          r_req_out     <= 1'b0;
          r_rd_wr_L_out <= 1'b0;
          r_addr_out    <= '0;
          r_data_out    <= '0;
          r_src_out     <= '0;
`ifdef REG_RING_TIMEOUT_EN
          r_tmo_cnt     <= '0;
`endif
          r_state       <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_claim) begin
            r_rsp_rdata <= reg_data_in;
            r_rsp_err   <= claim_status(reg_ack_in);
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
`ifdef REG_RING_TIMEOUT_EN
          else if (w_tmo_hit) begin
            r_tmo_cnt   <= TMO_W'(TIMEOUT_CYCLES);
            r_rsp_rdata <= TIMEOUT_FILL;
            r_rsp_err   <= ERR_TIMEOUT;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else if (r_tmo_cnt != TMO_W'(TIMEOUT_CYCLES)) begin
            r_tmo_cnt   <= r_tmo_cnt + TMO_W'(1);
          end
`endif
          else begin
            r_state     <= ST_WAIT;
          end
        end
        ST_RESP: begin
          if (cmd_if.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_rsp_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_req_out   <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_if.cmd_ready = r_cmd_ready;
  assign cmd_if.rsp_valid = r_rsp_valid;
  assign cmd_if.rsp_rdata = r_rsp_rdata;
  assign cmd_if.rsp_err   = r_rsp_err;

  assign reg_req_out      = r_req_out;
  assign reg_ack_out      = 1'b0;
  assign reg_rd_wr_L_out  = r_rd_wr_L_out;
  assign reg_addr_out     = r_addr_out;
  assign reg_data_out     = r_data_out;
  assign reg_src_out      = r_src_out;

endmodule

// File: tb/tb_reg_ring_initiator.sv
// Randomized bench for reg_ring_initiator against a register-space model of the ring.
module tb_reg_ring_initiator;
  import reg_ring_initiator_pkg::*;

  localparam int         SRCW   = 2;
  localparam logic [1:0] MY_SRC = 2'd1;
  localparam int         TMO    = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  reg_ring_initiator_if bus();

  logic        reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [22:0] reg_addr_out;
  logic [31:0] reg_data_out;
  logic [1:0]  reg_src_out;
  logic        reg_req_in, reg_ack_in, reg_rd_wr_L_in;
  logic [22:0] reg_addr_in;
  logic [31:0] reg_data_in;
  logic [1:0]  reg_src_in;

  reg_ring_initiator #(
    .UDP_REG_SRC_WIDTH(SRCW), .SRC_ID(MY_SRC), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cmd_if(bus.slave),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
    .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [logic [22:0]];
  logic [22:0] addr_pool [6] = '{23'h00_0000, 23'h00_0004, 23'h00_0008,
                                 23'h40_0004, 23'h00_00EE, 23'h00_01EE};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ring_idle();
    reg_req_in = 1'b0; reg_ack_in = 1'b0; reg_rd_wr_L_in = 1'b0;
    reg_addr_in = '0; reg_data_in = '0; reg_src_in = '0;
  endtask

  // Register space: addresses ending in 8'hEE have no responder on the ring.
  function automatic logic is_mapped(input logic [22:0] a);
    return a[7:0] != 8'hEE;
  endfunction

  function automatic logic [31:0] model_read(input logic [22:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h1234_5678 ^ {9'd0, a};
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0;
    ring_idle();
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic handshake(input logic rd, input logic [22:0] addr, input logic [31:0] wdata);
    int waited = 0;
    while (bus.cmd_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    chk("cmd_ready_timeout", 64'(waited < 20), 64'd1);
    bus.cmd_valid = 1'b1; bus.cmd_rd_wr_L = rd; bus.cmd_addr = addr; bus.cmd_wdata = wdata;
    tick();
    bus.cmd_valid = 1'b0; bus.cmd_rd_wr_L = ~rd; bus.cmd_addr = 23'($urandom); bus.cmd_wdata = $urandom;
    chk("issue_req", reg_req_out, 1'b1);
    chk("issue_src", reg_src_out, MY_SRC);
    chk("issue_addr", reg_addr_out, addr);
    chk("issue_rd", reg_rd_wr_L_out, rd);
    chk("issue_data", reg_data_out, wdata);
    chk("issue_ack0", reg_ack_out, 1'b0);
    chk("issue_cmd_ready", bus.cmd_ready, 1'b0);
  endtask

  // foreign: 0 none, 1 other src, 2 wrong addr, 3 req_in low
  task automatic do_txn(input logic rd, input logic [22:0] addr, input logic [31:0] wdata,
                        input int dly, input int foreign, input int bp);
    logic [31:0] exp_data;
    logic [1:0]  exp_err;
    logic        s_rd;
    logic [22:0] s_addr;
    logic [31:0] s_data;
    logic [1:0]  s_src;
    exp_err  = is_mapped(addr) ? 2'b00 : 2'b01;
    exp_data = (is_mapped(addr) && rd) ? model_read(addr) : wdata;
    handshake(rd, addr, wdata);
    s_rd = reg_rd_wr_L_out; s_addr = reg_addr_out; s_data = reg_data_out; s_src = reg_src_out;
    for (int i = 0; i <= dly; i++) begin
      tick();
      if (i == 0) chk("req_one_cycle", reg_req_out, 1'b0);
    end
    if (foreign != 0) begin
      reg_req_in = (foreign != 3); reg_ack_in = 1'b1; reg_rd_wr_L_in = s_rd;
      reg_addr_in = (foreign == 2) ? (s_addr ^ 23'h10) : s_addr;
      reg_data_in = 32'hBAD0_BAD0; reg_src_in = (foreign == 1) ? 2'd2 : s_src;
      tick();
      ring_idle();
      chk("foreign_ignored", bus.rsp_valid, 1'b0);
    end
    // Responder behaviour: owners ack and return read data; writes echo the data.
    reg_req_in = 1'b1; reg_ack_in = is_mapped(s_addr); reg_rd_wr_L_in = s_rd;
    reg_addr_in = s_addr; reg_src_in = s_src;
    reg_data_in = (is_mapped(s_addr) && s_rd) ? model_read(s_addr) : s_data;
    if (is_mapped(s_addr) && !s_rd) mem[s_addr] = s_data;
    tick();
    ring_idle();
    chk("rsp_valid", bus.rsp_valid, 1'b1);
    chk("rsp_rdata", bus.rsp_rdata, exp_data);
    chk("rsp_err", bus.rsp_err, exp_err);
    for (int i = 0; i < bp; i++) tick();
    if (bp > 0) begin
      chk("bp_valid", bus.rsp_valid, 1'b1);
      chk("bp_rdata", bus.rsp_rdata, exp_data);
      chk("bp_err", bus.rsp_err, exp_err);
      chk("bp_cmd_ready", bus.cmd_ready, 1'b0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("rsp_single_pulse", bus.rsp_valid, 1'b0);
    chk("ready_after_rsp", bus.cmd_ready, 1'b1);
  endtask

  initial begin
    int cnt;
    bus.cmd_valid = 1'b0; bus.cmd_rd_wr_L = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    ring_idle();
    reset_n = 1'b0;
    tick(); tick();
    chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_err", bus.rsp_err, 2'b00);
    chk("rst_ring_out", {reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out}, 64'd0);
    reset_n = 1'b1;
    #1;
    chk("rel_cmd_ready_low", bus.cmd_ready, 1'b0);
    tick();
    chk("rel_cmd_ready_high", bus.cmd_ready, 1'b1);

    do_txn(1'b1, 23'h00_0000, 32'h0000_0042, 3, 0, 0);
    do_txn(1'b0, 23'h40_0004, 32'hA5A5_0001, 1, 0, 0);
    do_txn(1'b1, 23'h40_0004, 32'h0, 0, 0, 0);
    do_txn(1'b1, 23'h00_00EE, 32'h7777_0000, 2, 0, 0);
    do_txn(1'b1, 23'h40_0004, 32'h0, 2, 1, 0);
    do_txn(1'b0, 23'h00_0008, 32'h0F0F_F0F0, 1, 0, 5);

    for (int k = 0; k < 40; k++) begin
      do_txn(1'($urandom), addr_pool[$urandom_range(0, 5)], $urandom,
             int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

`ifdef REG_RING_TIMEOUT_EN
    handshake(1'b1, 23'h00_0004, 32'h0);
    cnt = 0;
    while (bus.rsp_valid !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("tmo_latency", cnt, 17);
    chk("tmo_err", bus.rsp_err, 2'b10);
    chk("tmo_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("tmo_rsp_done", bus.rsp_valid, 1'b0);
`else
    handshake(1'b1, 23'h00_0004, 32'h0);
    for (int i = 0; i < 1000; i++) tick();
    chk("no_tmo_still_waiting", bus.rsp_valid, 1'b0);
    chk("no_tmo_cmd_ready", bus.cmd_ready, 1'b0);
    do_reset();
    cnt = 0;
`endif

    // Reset while waiting for a return.
    handshake(1'b1, 23'h00_0008, 32'h1111_2222);
    tick(); tick();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", bus.cmd_ready, 1'b0);
    chk("mid_rst_rsp", {bus.rsp_valid, bus.rsp_rdata, bus.rsp_err}, 64'd0);
    chk("mid_rst_ring_out", {reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out}, 64'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    reg_req_in = 1'b1; reg_ack_in = 1'b1; reg_rd_wr_L_in = 1'b1;
    reg_addr_in = 23'h00_0008; reg_data_in = 32'hCAFE_0000; reg_src_in = MY_SRC;
    tick();
    ring_idle();
    chk("late_return_ignored", bus.rsp_valid, 1'b0);
    chk("late_return_ready", bus.cmd_ready, 1'b1);
    do_txn(1'b1, 23'h00_0008, 32'h0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
